// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_pkg;

    localparam int WIDTH     = 32;
    localparam int ITER_LAST = WIDTH - 1;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE,
        DZERO
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the main control unit and the mul/div sequencer.
interface muldiv_if #(
    parameter int WIDTH = muldiv_pkg::WIDTH
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             hi_we;
    logic             lo_we;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, div_zero, hi_out, lo_out, hi_we, lo_we
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, div_zero, hi_out, lo_out, hi_we, lo_we
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration: Booth add/sub + arithmetic shift (mult) or restoring shift/subtract (div).
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = muldiv_pkg::WIDTH
) (
    input  logic             op_i,
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             qm1_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             qm1_o
);
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        m_ext   = (op_i == OP_DIV) ? {1'b0, m_i} : {m_i[WIDTH-1], m_i};
        sum     = acc_i;
        shifted = {acc_i[WIDTH-1:0], lo_i[WIDTH-1]};
        trial   = shifted - m_ext;
        acc_o   = acc_i;
        lo_o    = lo_i;
        qm1_o   = 1'b0;
        if (op_i == OP_MULT) begin
            case ({lo_i[0], qm1_i})
                2'b01:   sum = acc_i + m_ext;
                2'b10:   sum = acc_i - m_ext;
                default: sum = acc_i;
            endcase
            acc_o = {sum[WIDTH], sum[WIDTH:1]};
            lo_o  = {sum[0], lo_i[WIDTH-1:1]};
            qm1_o = lo_i[0];
        end else if (!trial[WIDTH]) begin
            // Remainder stays below the divisor, so bit WIDTH of trial is a clean borrow flag.
            acc_o = trial;
            lo_o  = {lo_i[WIDTH-2:0], 1'b1};
        end else begin
            acc_o = shifted;
            lo_o  = {lo_i[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply/divide controller feeding HI/LO.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = muldiv_pkg::WIDTH,
    parameter int CNT_W = 6
) (
    input  logic     clock,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] work_q, m_q;
    logic             qm1_q, op_q, qneg_q, rneg_q;
    logic             busy_q, done_q, dz_q, we_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic [WIDTH:0]   acc_d;
    logic [WIDTH-1:0] work_d;
    logic             qm1_d;
    logic [WIDTH-1:0] a_mag, b_mag, rem_mag, hi_fix, lo_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op_i  (op_q),
        .acc_i (acc_q),
        .lo_i  (work_q),
        .qm1_i (qm1_q),
        .m_i   (m_q),
        .acc_o (acc_d),
        .lo_o  (work_d),
        .qm1_o (qm1_d)
    );

    always_comb begin
        a_mag   = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
        b_mag   = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;
        rem_mag = acc_q[WIDTH-1:0];
        hi_fix  = rem_mag;
        lo_fix  = work_q;
        if (op_q == OP_DIV) begin
            hi_fix = rneg_q ? -rem_mag : rem_mag;
            lo_fix = qneg_q ? -work_q : work_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            work_q  <= '0;
            m_q     <= '0;
            qm1_q   <= 1'b0;
            op_q    <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            we_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        cnt_q  <= '0;
                        acc_q  <= '0;
                        qm1_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (bus.op == OP_MULT) begin
                            m_q     <= bus.a_in;
                            work_q  <= bus.b_in;
                            state_q <= MULT;
                        end else if (bus.b_in == '0) begin
                            dz_q    <= 1'b1;
                            state_q <= DZERO;
                        end else begin
                            m_q     <= b_mag;
                            work_q  <= a_mag;
                            qneg_q  <= bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
                            rneg_q  <= bus.a_in[WIDTH-1];
                            state_q <= DIV;
                        end
                    end
                end
                MULT, DIV: begin
                    acc_q  <= acc_d;
                    work_q <= work_d;
                    qm1_q  <= qm1_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= hi_fix;
                    lo_q    <= lo_fix;
                    done_q  <= 1'b1;
                    we_q    <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                DZERO: begin
                    dz_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;
    assign bus.hi_we    = we_q;
    assign bus.lo_we    = we_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // Cycle k is observed at the falling edge after the k-th rising edge following acceptance.
    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          output int done_cyc, output int done_cnt, output int busy_first,
                          output int busy_last, output int busy_cnt, output int dz_cyc,
                          output int dz_cnt, output int we_bad,
                          output logic [31:0] hi, output logic [31:0] lo);
        done_cyc = -1; done_cnt = 0; busy_first = -1; busy_last = -1; busy_cnt = 0;
        dz_cyc = -1; dz_cnt = 0; we_bad = 0; hi = 'x; lo = 'x;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a_in = a; bus.b_in = b;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = k;
                busy_last = k;
            end
            if (bus.done) begin
                done_cnt++; done_cyc = k; hi = bus.hi_out; lo = bus.lo_out;
                if (!(bus.hi_we && bus.lo_we)) we_bad++;
            end else if (bus.hi_we || bus.lo_we) we_bad++;
            if (bus.div_zero) begin dz_cnt++; dz_cyc = k; end
            if (k == 1) begin
                bus.start = 1'b0; bus.a_in = 32'h1234_5678; bus.b_in = 32'h0000_0000;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if ({bus.done, bus.div_zero, bus.hi_we, bus.lo_we} !== 4'b0000) begin
            errors++; $display("FAIL reset_pulses: got %b want 0000", {bus.done, bus.div_zero, bus.hi_we, bus.lo_we}); end
        checks++; if ({bus.hi_out, bus.lo_out} !== 64'h0) begin
            errors++; $display("FAIL reset_hilo: got %h_%h want 0_0", bus.hi_out, bus.lo_out); end
        rst_n = 1'b1;
    endtask

    task automatic test_mult();
        int dc, dn, bf, bl, bn, zc, zn, wb; logic [31:0] hi, lo;
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, dc, dn, bf, bl, bn, zc, zn, wb, hi, lo);
        checks++; if (dc !== 34 || dn !== 1) begin errors++; $display("FAIL mult_done: cycle %0d count %0d want 34/1", dc, dn); end
        checks++; if (bf !== 1 || bl !== 34 || bn !== 34) begin
            errors++; $display("FAIL mult_busy: first %0d last %0d n %0d want 1/34/34", bf, bl, bn); end
        checks++; if (wb !== 0) begin errors++; $display("FAIL mult_we: bad %0d want 0", wb); end
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            errors++; $display("FAIL mult_7x-3: got %h_%h want ffffffff_ffffffeb", hi, lo); end
    endtask

    task automatic test_mult_extreme();
        int dc, dn, bf, bl, bn, zc, zn, wb; logic [31:0] hi, lo;
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, dc, dn, bf, bl, bn, zc, zn, wb, hi, lo);
        checks++; if (dc !== 34 || hi !== 32'h4000_0000 || lo !== 32'h0) begin
            errors++; $display("FAIL mult_extreme: cycle %0d got %h_%h want 34 40000000_00000000", dc, hi, lo); end
    endtask

    task automatic test_div();
        int dc, dn, bf, bl, bn, zc, zn, wb; logic [31:0] hi, lo;
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, dc, dn, bf, bl, bn, zc, zn, wb, hi, lo);
        checks++; if (dc !== 34 || dn !== 1 || wb !== 0) begin
            errors++; $display("FAIL div_timing: cycle %0d count %0d we_bad %0d want 34/1/0", dc, dn, wb); end
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            errors++; $display("FAIL div_-7/2: got %h_%h want ffffffff_fffffffd", hi, lo); end
        run_op(1'b1, 32'd100, 32'd7, dc, dn, bf, bl, bn, zc, zn, wb, hi, lo);
        checks++; if (hi !== 32'd2 || lo !== 32'd14) begin
            errors++; $display("FAIL div_100/7: got %h_%h want 00000002_0000000e", hi, lo); end
    endtask

    task automatic test_div_zero();
        int dc, dn, bf, bl, bn, zc, zn, wb; logic [31:0] hi, lo;
        run_op(1'b1, 32'd5, 32'd0, dc, dn, bf, bl, bn, zc, zn, wb, hi, lo);
        checks++; if (zc !== 1 || zn !== 1) begin errors++; $display("FAIL dz_pulse: cycle %0d count %0d want 1/1", zc, zn); end
        checks++; if (bf !== 1 || bn !== 1) begin errors++; $display("FAIL dz_busy: first %0d n %0d want 1/1", bf, bn); end
        checks++; if (dn !== 0 || wb !== 0) begin errors++; $display("FAIL dz_nodone: done %0d we_bad %0d want 0/0", dn, wb); end
        checks++; if (bus.hi_out !== 32'd2 || bus.lo_out !== 32'd14) begin
            errors++; $display("FAIL dz_hold: got %h_%h want 00000002_0000000e", bus.hi_out, bus.lo_out); end
    endtask

    task automatic test_overflow();
        int dc, dn, bf, bl, bn, zc, zn, wb; logic [31:0] hi, lo;
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, dc, dn, bf, bl, bn, zc, zn, wb, hi, lo);
        checks++; if (dc !== 34 || hi !== 32'h0 || lo !== 32'h8000_0000) begin
            errors++; $display("FAIL div_wrap: cycle %0d got %h_%h want 34 00000000_80000000", dc, hi, lo); end
    endtask

    task automatic test_start_held();
        int dn = 0, dc = -1; logic [31:0] hi = 'x, lo = 'x;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.a_in = 32'd3; bus.b_in = 32'd5;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done) begin dn++; dc = k; hi = bus.hi_out; lo = bus.lo_out; end
            bus.start = (k >= 5 && k <= 20);
            bus.op = 1'b1; bus.a_in = 32'd99; bus.b_in = 32'd0;
        end
        checks++; if (dn !== 1 || dc !== 34) begin errors++; $display("FAIL held_start: done count %0d cycle %0d want 1/34", dn, dc); end
        checks++; if (hi !== 32'd0 || lo !== 32'd15) begin errors++; $display("FAIL held_result: got %h_%h want 0_0000000f", hi, lo); end
    endtask

    task automatic test_back_to_back();
        int dn = 0, d1 = -1, d2 = -1;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.a_in = 32'd4; bus.b_in = 32'd6;
        for (int k = 1; k <= 75; k++) begin
            @(negedge clk);
            if (bus.done) begin dn++; if (d1 < 0) d1 = k; else d2 = k; end
            bus.start = (k <= 35);
        end
        checks++; if (dn !== 2 || d1 !== 34 || d2 !== 69) begin
            errors++; $display("FAIL back_to_back: count %0d cycles %0d,%0d want 2 34,69", dn, d1, d2); end
    endtask

    task automatic test_reset_mid();
        int bad = 0, dc = -1; logic [31:0] hi = 'x, lo = 'x;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.a_in = 32'd9; bus.b_in = 32'd9;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k == 11) begin
                checks++; if (bus.busy !== 1'b0 || {bus.hi_out, bus.lo_out} !== 64'h0) begin
                    errors++; $display("FAIL mid_reset_state: busy %b hilo %h_%h want 0 0_0", bus.busy, bus.hi_out, bus.lo_out); end
            end
            if (k >= 11 && k <= 45 && (bus.done || bus.hi_we || bus.lo_we || bus.busy && k < 13)) bad++;
            if (bus.done && k > 45) begin dc = k; hi = bus.hi_out; lo = bus.lo_out; end
            bus.start = (k == 1 || k == 12);
            rst_n = (k != 10);
            if (k == 12) begin bus.op = 1'b0; bus.a_in = 32'hFFFF_FFFE; bus.b_in = 32'd6; end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL mid_reset_quiet: stray cycles %0d want 0", bad); end
        checks++; if (dc !== 46 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF4) begin
            errors++; $display("FAIL mid_reset_restart: cycle %0d got %h_%h want 46 ffffffff_fffffff4", dc, hi, lo); end
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 1'b0; bus.a_in = '0; bus.b_in = '0;
        test_reset();
        test_mult();
        test_mult_extreme();
        test_div();
        test_div_zero();
        test_overflow();
        test_start_held();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
